// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants, FSM states and FIFO entry type for the burst reader
package regfile_pkg;

  localparam int DEF_WORD_LENGTH = 32;
  localparam int DEF_ADDR_WIDTH  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0]  addr;
    logic [DEF_WORD_LENGTH-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/regfile_burst_reader_if.sv
// rtl/regfile_burst_reader_if.sv - output word stream of the burst reader (valid/ready with address tag)
interface regfile_burst_reader_if
  import regfile_pkg::*;
#(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
);

  logic                   out_valid;
  logic                   out_ready;
  logic [WORD_LENGTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0]  out_addr;

  modport master (output out_valid, output out_data, output out_addr, input out_ready);
  modport slave  (input out_valid, input out_data, input out_addr, output out_ready);

endinterface

// File: rtl/skid_fifo2.sv
// rtl/skid_fifo2.sv - two-entry FIFO; a push into a full FIFO is dropped even if a pop happens that cycle
module skid_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   occupancy
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         rd_q, rd_d;
  logic         wr_q, wr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  assign full      = (cnt_q == 2'd2);
  assign empty     = (cnt_q == 2'd0);
  assign occupancy = cnt_q;
  assign head      = mem_q[rd_q];

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    do_push = push && !full;
    do_pop  = pop && !empty;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = ~wr_q;
    end
    if (do_pop) begin
      rd_d = ~rd_q;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_burst_reader.sv
// rtl/regfile_burst_reader.sv - walks consecutive register addresses and streams {addr, data} words out
module regfile_burst_reader
  import regfile_pkg::*;
#(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [ADDR_WIDTH:0]    count,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH-1:0]  rf_rd_addr,
  input  logic [WORD_LENGTH-1:0] rf_rd_data,
  regfile_burst_reader_if.master out_if
);

  localparam int EW = ADDR_WIDTH + WORD_LENGTH;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  done_q, done_d;

  logic          push, pop, full, empty;
  logic [1:0]    occupancy;
  logic [EW-1:0] head;

  skid_fifo2 #(.W(EW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({ptr_q, rf_rd_data}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .occupancy (occupancy)
  );

  assign pop              = !empty && out_if.out_ready;
  assign out_if.out_valid = !empty;
  assign out_if.out_addr  = head[EW-1 -: ADDR_WIDTH];
  assign out_if.out_data  = head[WORD_LENGTH-1:0];
  assign busy             = (state_q != IDLE);
  assign done             = done_q;
  assign rf_rd_addr       = rd_addr_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    rd_addr_d   = rd_addr_q;
    done_d      = 1'b0;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            ptr_d       = base_addr;
            remaining_d = count;
            rd_addr_d   = base_addr;
            state_d     = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        push = !full;
        if (push) begin
          ptr_d       = ptr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          // Last push: leave the read address on the final register read.
          if (remaining_q == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
            state_d = DRAIN;
          end else begin
            rd_addr_d = ptr_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (pop && occupancy == 2'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      rd_addr_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      rd_addr_q   <= rd_addr_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_regfile_burst_reader.sv
// tb/tb_regfile_burst_reader.sv - randomized bench with a queue-based reference model of burst reads
module tb_regfile_burst_reader;
  import regfile_pkg::*;

  localparam int WL   = DEF_WORD_LENGTH;
  localparam int AW   = DEF_ADDR_WIDTH;
  localparam int NREG = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic          busy;
  logic          done;
  logic [AW-1:0] rf_rd_addr;
  logic [WL-1:0] rf_rd_data;
  logic [WL-1:0] rf [NREG];

  int n_checks = 0;
  int n_errors = 0;

  regfile_burst_reader_if #(.WORD_LENGTH(WL), .ADDR_WIDTH(AW)) oif ();

  regfile_burst_reader #(.WORD_LENGTH(WL), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .out_if     (oif.master)
  );

  always #5 clk = ~clk;

  assign rf_rd_data = rf[rf_rd_addr];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < NREG; i++) rf[i] = WL'(i * 16 + 15);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NREG; i++) rf[i] = $urandom;
  endtask

  // Cycle 0 is the cycle start is presented; cycle c is c clocks later.
  task automatic run_burst(input int base, input int cnt, input int stall_at,
                           input int stall_len, input bit poke_start);
    fifo_entry_t   exp_q[$];
    fifo_entry_t   e;
    bit            seen_done  = 1'b0;
    bit            prev_stall = 1'b0;
    logic [AW-1:0] prev_a     = '0;
    logic [WL-1:0] prev_d     = '0;
    int            budget     = cnt + stall_len + 10;
    for (int i = 0; i < cnt; i++) begin
      e.addr = AW'((base + i) % NREG);
      e.data = rf[e.addr];
      exp_q.push_back(e);
    end
    @(negedge clk);
    start         = 1'b1;
    base_addr     = AW'(base);
    count         = (AW + 1)'(cnt);
    oif.out_ready = 1'b1;
    for (int c = 1; c <= budget && !seen_done; c++) begin
      @(negedge clk);
      oif.out_ready = !(c >= stall_at && c < stall_at + stall_len);
      if (poke_start && c <= 2) begin
        start     = 1'b1;
        base_addr = AW'($urandom);
        count     = (AW + 1)'($urandom_range(1, NREG));
      end else begin
        start = 1'b0;
      end
      if (c == 1) check_eq("busy_first", busy, cnt != 0);
      if (prev_stall && oif.out_valid) begin
        check_eq("stall_addr", oif.out_addr, prev_a);
        check_eq("stall_data", oif.out_data, prev_d);
      end
      if (stall_len >= 3 && c == stall_at + stall_len - 1 && exp_q.size() >= 3)
        check_eq("full_hold_addr", rf_rd_addr, exp_q[2].addr);
      if (oif.out_valid && oif.out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("word_addr", oif.out_addr, e.addr);
          check_eq("word_data", oif.out_data, e.data);
        end
      end
      if (stall_len == 0)
        check_eq("valid_timing", oif.out_valid, (cnt != 0) && c >= 2 && c <= cnt + 1);
      if (done) begin
        seen_done = 1'b1;
        check_eq("done_with_valid", oif.out_valid, 0);
        check_eq("words_left", exp_q.size(), 0);
        if (stall_len == 0) check_eq("done_cycle", c, (cnt == 0) ? 1 : cnt + 2);
      end
      prev_stall = oif.out_valid && !oif.out_ready;
      prev_a     = oif.out_addr;
      prev_d     = oif.out_data;
    end
    check_eq("done_seen", seen_done, 1);
    @(negedge clk);
    start = 1'b0;
    check_eq("done_pulse", done, 0);
    check_eq("busy_after", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    base_addr     = '0;
    count         = '0;
    oif.out_ready = 1'b0;
    fill_pattern();
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_valid", oif.out_valid, 0);
    check_eq("rst_data", oif.out_data, 0);
    check_eq("rst_addr", oif.out_addr, 0);
    check_eq("rst_rd_addr", rf_rd_addr, 0);
    reset = 1'b0;

    run_burst(3, 4, 0, 0, 1'b0);
    run_burst(30, 4, 0, 0, 1'b0);
    run_burst(7, 6, 3, 5, 1'b0);
    run_burst(5, 0, 0, 0, 1'b0);
    run_burst(12, 5, 0, 0, 1'b1);

    // Reset while two words sit in the FIFO.
    @(negedge clk);
    start = 1'b1; base_addr = AW'(10); count = (AW + 1)'(6); oif.out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("pre_rst_valid", oif.out_valid, 1);
    check_eq("pre_rst_addr", oif.out_addr, 10);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_valid", oif.out_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_done", done, 0);
    reset = 1'b0;
    oif.out_ready = 1'b1;
    @(negedge clk);
    check_eq("post_rst_done", done, 0);
    check_eq("post_rst_valid", oif.out_valid, 0);
    run_burst(20, 3, 0, 0, 1'b0);

    run_burst(0, 32, 0, 0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      fill_random();
      run_burst($urandom_range(0, NREG - 1), $urandom_range(1, NREG),
                $urandom_range(1, 8), $urandom_range(0, 6), 1'(k % 2));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_burst_reader.md
# regfile_burst_reader

Burst read engine for the register file's read port. It is the reader-side counterpart of the enable-gated `Register` write path. On `start` it walks `count` consecutive register addresses from `base_addr`, wrapping modulo the register count, and samples the register file's combinational read data. It streams each word, tagged with its address, through a 2-entry buffer onto a valid/ready output. Debug and readback logic uses it to dump register contents without stalling writers.

## Interface
- `WORD_LENGTH`, 32, data width of each register
- `ADDR_WIDTH`, 5, register address width (2^ADDR_WIDTH registers)

- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  request a burst; sampled only in IDLE
- `base_addr`  in  ADDR_WIDTH  first address of burst, sampled with `start`
- `count`  in  ADDR_WIDTH+1  words to read, 0..2^ADDR_WIDTH, sampled with `start`
- `busy`  out  1  high while a burst is in progress
- `done`  out  1  one-cycle pulse at burst completion
- `rf_rd_addr`  out  ADDR_WIDTH  read address to register file read mux
- `rf_rd_data`  in  WORD_LENGTH  register file read data, combinational from `rf_rd_addr`, same cycle
- `out_valid`  out  1  output word available
- `out_ready`  in  1  consumer accepts word
- `out_data`  out  WORD_LENGTH  register contents
- `out_addr`  out  ADDR_WIDTH  address `out_data` was read from

## Operation
- FSM states are IDLE, RUN and DRAIN.
- IDLE:
  - `start`=1 with `count`≠0: latch `ptr`←`base_addr` and `remaining`←`count`, go to RUN.
  - `start`=1 with `count`=0: stay in IDLE and pulse `done` next cycle.
- RUN:
  - `rf_rd_addr`=`ptr`.
  - Push when occupancy<2. A push stores {`ptr`, `rf_rd_data`} into the FIFO, sets `ptr`←`ptr`+1 (wraps 2^ADDR_WIDTH−1→0) and `remaining`←`remaining`−1.
  - When a push makes `remaining` 0, go to DRAIN.
- DRAIN: no pushes. When the FIFO becomes empty via a pop, go to IDLE and pulse `done` the next cycle.
- Output side:
  - `out_valid`=FIFO non-empty, with `out_data`/`out_addr` taken from the FIFO head.
  - A pop occurs when `out_valid`&&`out_ready`.
  - Head data stays stable while `out_valid`=1 and `out_ready`=0.
- No push when full, even if a pop happens the same cycle. Occupancy 1 with push+pop each cycle sustains one word per cycle.
- `start` is ignored while `busy`=1.
- `busy`=1 in RUN and DRAIN.
- `rf_rd_addr` holds its last value outside RUN.
- Data is sampled at the push edge. A register-file write landing in the same cycle returns the old value (register-file behaviour).
- `count`=2^ADDR_WIDTH reads every register exactly once, starting at `base_addr`.

## Timing
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_data`=0, `out_addr`=0, `rf_rd_addr`=0, FIFO empty, state IDLE.
- Reset mid-burst: all state returns to reset values at the next edge, the FIFO is flushed, and no `done` is generated.
- With `start` at edge T and `out_ready` held 1:
  - `busy`=1 from T+1.
  - Pushes occur at T+1..T+N.
  - `out_valid`=1 at T+2..T+N+1.
  - At T+N+2, `done`=1 and `busy`=0.
- `count`=0: `done`=1 at T+1, `busy` stays 0.
- With `out_ready`=0, the FIFO fills to 2 and pushes stop. `rf_rd_addr` holds `ptr` until space frees.
- `done` is never asserted in the same cycle as `out_valid`.

## Structure
- Package `regfile_pkg` holds:
  - default `WORD_LENGTH`/`ADDR_WIDTH` constants
  - FSM state enum (IDLE/RUN/DRAIN)
  - FIFO entry struct {addr, data}
- Sub-module `skid_fifo2` is a 2-entry FIFO with push/pop/full/empty/occupancy, parameterized on entry width.
- The FSM, `ptr` and `remaining` live in the top level.

## Test plan
- Register file preloaded with R[i]=i*16+15; `base_addr`=3, `count`=4, `out_ready`=1 → outputs (3,63),(4,79),(5,95),(6,111) on consecutive cycles; `done` on the cycle after the last word.
- `base_addr`=30, `count`=4, ADDR_WIDTH=5 → addresses 30,31,0,1 in order.
- `count`=6 with `out_ready` low for 5 cycles mid-burst → occupancy stops at 2, no word lost or duplicated, head stable while stalled, all 6 words in order.
- `count`=0 → `done` pulses at T+1, `busy` stays 0, `out_valid` never asserts; `start` during `busy` is ignored.
- `reset` asserted with 2 words buffered → next cycle `out_valid`=0, `busy`=0, no `done`; a new burst afterward runs correctly.
- `count`=32 from `base_addr`=0 → all 32 registers emitted exactly once, `done` at T+34.
